rom_arbiter: RTL

- Shares the single-port synchronous program ROM (1-cycle read latency, address registered on posedge clk) between two requesters: port 0 (instruction fetch) and port 1 (data load of constants/rodata).
- Round-robin grant on conflict. Tracks which port owns the in-flight read and routes the returned word back to that port with a valid pulse.
- Sits between the core's fetch/LSU front-ends and the ROM instance.

---
 rtl/rom_arb_pkg.sv | 18 +
 rtl/rom_arbiter_if.sv | 30 +++
 rtl/rom_arbiter_rr_arb2.sv | 22 ++
 rtl/rom_arbiter.sv | 119 +++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the program-ROM arbiter.
// ARB_LATENCY tracks ROM_ARB_OUTREG_EN (grant-to-rvalid cycles).
package rom_arb_pkg;

  typedef enum logic {
    PORT_IFETCH = 1'b0,
    PORT_DLOAD  = 1'b1
  } port_id_t;

  localparam int NUM_PORTS = 2;

`ifdef ROM_ARB_OUTREG_EN
  localparam int ARB_LATENCY = 2;
`else
  localparam int ARB_LATENCY = 1;
`endif

endpackage

// File: rtl/rom_arbiter_if.sv
// Requester-side and ROM-side signals of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding core/ROM view.
interface rom_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  req0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic                  gnt0;
  logic                  rvalid0;
  logic [DATA_WIDTH-1:0] rdata0;
  logic                  req1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic                  gnt1;
  logic                  rvalid1;
  logic [DATA_WIDTH-1:0] rdata1;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_rdata;
  logic                  rom_rdata_valid;

  modport slave (
    input  req0, addr0, req1, addr1, rom_rdata, rom_rdata_valid,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, rom_addr
  );

  modport master (
    output req0, addr0, req1, addr1, rom_rdata, rom_rdata_valid,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, rom_addr
  );
endinterface

// File: rtl/rom_arbiter_rr_arb2.sv
// Two-way round-robin picker, purely combinational, one-hot (or zero) grant.
// On conflict the port that did not win last time is chosen.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one single-port synchronous ROM between fetch (port 0) and data load (port 1).
// Define ROM_ARB_OUTREG_EN to re-register rdata*/rvalid* (grant-to-rvalid 2 cycles instead of 1).
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input logic          clk,
  input logic          reset_n,
  rom_arbiter_if.slave bus
);

  logic [NUM_PORTS-1:0]  gnt;
  logic                  stall;
  logic                  arb_en;
  logic                  any_gnt;
  logic                  rsp_vld;
  logic [1:0]            rsp_vld_port;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rsp_dat0;
  logic [DATA_WIDTH-1:0] rsp_dat1;

  logic                  pend_q,      pend_d;
  port_id_t              pend_id_q,   pend_id_d;
  logic                  last_gnt_q,  last_gnt_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_WIDTH-1:0] hold0_q;
  logic [DATA_WIDTH-1:0] hold1_q;

  assign stall   = pend_q & ~bus.rom_rdata_valid;
  assign arb_en  = reset_n & ~stall;
  assign any_gnt = |gnt;
  assign rsp_vld = pend_q & bus.rom_rdata_valid;

  rr_arb2 u_rr_arb2 (
    .req      ({bus.req1, bus.req0}),
    .last_gnt (last_gnt_q),
    .en       (arb_en),
    .gnt      (gnt)
  );

  assign bus.gnt0 = gnt[0];
  assign bus.gnt1 = gnt[1];

  // Idle value is addr0 so the ROM address never floats.
  always_comb begin
    rom_addr = bus.addr0;
    if (gnt[1])     rom_addr = bus.addr1;
    else if (stall) rom_addr = pend_addr_q;
  end
  assign bus.rom_addr = rom_addr;

  always_comb begin
    pend_d      = pend_q;
    pend_id_d   = pend_id_q;
    last_gnt_d  = last_gnt_q;
    pend_addr_d = pend_addr_q;
    if (any_gnt) begin
      pend_d      = 1'b1;
      pend_id_d   = gnt[1] ? PORT_DLOAD : PORT_IFETCH;
      last_gnt_d  = gnt[1];
      pend_addr_d = rom_addr;
    end else if (rsp_vld) begin
      pend_d = 1'b0;
    end
  end

  // The returned word is steered to the owner; the other port keeps its last word.
  assign rsp_vld_port[0] = rsp_vld & (pend_id_q == PORT_IFETCH);
  assign rsp_vld_port[1] = rsp_vld & (pend_id_q == PORT_DLOAD);
  assign rsp_dat0 = rsp_vld_port[0] ? bus.rom_rdata : hold0_q;
  assign rsp_dat1 = rsp_vld_port[1] ? bus.rom_rdata : hold1_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_q      <= 1'b0;
      pend_id_q   <= PORT_IFETCH;
      last_gnt_q  <= 1'b1;
      pend_addr_q <= '0;
      hold0_q     <= '0;
      hold1_q     <= '0;
    end else begin
      pend_q      <= pend_d;
      pend_id_q   <= pend_id_d;
      last_gnt_q  <= last_gnt_d;
      pend_addr_q <= pend_addr_d;
      hold0_q     <= rsp_dat0;
      hold1_q     <= rsp_dat1;
    end
  end

`ifdef ROM_ARB_OUTREG_EN
  logic [1:0] out_vld_q;

  always_ff @(posedge clk) begin
    if (!reset_n) out_vld_q <= 2'b00;
    else          out_vld_q <= rsp_vld_port;
  end

  assign bus.rvalid0 = reset_n & out_vld_q[0];
  assign bus.rvalid1 = reset_n & out_vld_q[1];
  assign bus.rdata0  = reset_n ? hold0_q : '0;
  assign bus.rdata1  = reset_n ? hold1_q : '0;
`else
  assign bus.rvalid0 = reset_n & rsp_vld_port[0];
  assign bus.rvalid1 = reset_n & rsp_vld_port[1];
  assign bus.rdata0  = reset_n ? rsp_dat0 : '0;
  assign bus.rdata1  = reset_n ? rsp_dat1 : '0;
`endif

`ifdef SIMULATION
  a_addr0_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (bus.req0 && !bus.gnt0) |=> (!bus.req0 || $stable(bus.addr0)));
  a_addr1_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (bus.req1 && !bus.gnt1) |=> (!bus.req1 || $stable(bus.addr1)));
`endif

endmodule
